// File: rtl/fifo_to_axi4m_pkg.sv
// ---------------------------------------------------------------------------
// fifo_to_axi4m_pkg
//
// Shared definitions for the FIFO-to-AXI4 write DMA engine:
//   - state_e          : engine state encoding
//   - MAX_BURST_LENGTH : longest INCR burst the engine issues (beats)
//   - BURST_INCR, CACHE_DEFAULT, RESP_OKAY : fixed AXI field values
//   - axiSize()        : AWSIZE encoding for a given data bus width
//
// Optional feature macro used by the engine: FIFO_TO_AXI4M_BRESP_ERR_EN
// ---------------------------------------------------------------------------
package fifo_to_axi4m_pkg;

   typedef enum logic [2:0] {
      s_idle      = 3'd0,
      s_kick      = 3'd1,
      s_addrcalc  = 3'd2,
      s_addrissue = 3'd3,
      s_data      = 3'd4,
      s_respwait  = 3'd5
   } state_e;

   localparam int         MAX_BURST_LENGTH = 64;
   localparam logic [1:0] BURST_INCR       = 2'b01;
   localparam logic [3:0] CACHE_DEFAULT    = 4'b0010;
   localparam logic [1:0] RESP_OKAY        = 2'b00;

   // AWSIZE is log2 of the number of bytes per beat
   function automatic logic [2:0] axiSize(input int dataWidth);
      return 3'($clog2(dataWidth / 8));
   endfunction

endpackage

// File: rtl/fifo_to_axi4m_if.sv
// ---------------------------------------------------------------------------
// fifo_to_axi4m_if
//
// AXI4 write-only bus (AW, W, B channels) between the DMA engine and memory.
// Modports:
//   master : engine side, drives AW/W payload+valid and BREADY
//   slave  : memory side, drives AWREADY, WREADY and the B channel
// Parameters: ID_WIDTH, ADDR_WIDTH, DATA_WIDTH
// ---------------------------------------------------------------------------
interface fifo_to_axi4m_if #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic [0:0]              awlock;
   logic [3:0]              awcache;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;

   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/fifo_to_axi4m_axi_burst_calc.sv
// ---------------------------------------------------------------------------
// axi_burst_calc
//
// Combinational burst slicer shared by the read and write DMA engines.
// Given the words still to move and the current byte address it produces
// the AWLEN/ARLEN of the next burst (at most MAX_BURST_LENGTH beats), the
// address following that burst and the words left afterwards.
// Ports:
//   remaining_i     : words not yet covered by an issued burst
//   addr_i          : byte address of the next burst
//   awlen_o         : beats-1 of the next burst
//   nextAddr_o      : byte address after the next burst (wraps)
//   nextRemaining_o : remaining_i minus the next burst length
// ---------------------------------------------------------------------------
module axi_burst_calc
   import fifo_to_axi4m_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic [31:0]           remaining_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [7:0]            awlen_o,
   output logic [ADDR_WIDTH-1:0] nextAddr_o,
   output logic [31:0]           nextRemaining_o
);

   localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

   logic [6:0] burstLen;

   // Clamp to the maximum burst, then derive address and count advances.
   // The address advance is a shift because bytes per beat is a power of two.
   always_comb begin
      burstLen = 7'(MAX_BURST_LENGTH);
      if (remaining_i < 32'(MAX_BURST_LENGTH)) begin
         burstLen = remaining_i[6:0];
      end
      awlen_o         = {1'b0, burstLen} - 8'd1;
      nextAddr_o      = addr_i + (ADDR_WIDTH'(burstLen) << BYTE_SHIFT);
      nextRemaining_o = remaining_i - 32'(burstLen);
   end

endmodule

// File: rtl/fifo_to_axi4m.sv
// ---------------------------------------------------------------------------
// fifo_to_axi4m
//
// Write-side DMA engine: on kick, drains write_num words from a first-word-
// fall-through FIFO to memory starting at write_addr, as a sequence of AXI4
// INCR bursts of at most 64 beats. One burst is outstanding at a time:
// AW handshake, then the W beats, then the B response.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   kick, busy        : start pulse (honoured only when idle), activity flag
//   write_num         : number of words to move (latched on start)
//   write_addr        : start byte address (latched on start)
//   buf_din/buf_empty : FIFO head word and empty flag
//   buf_re            : FIFO pop, one per accepted W beat
//   err               : sticky bad-BRESP flag (only with the macro below)
//   m_axi             : AXI4 write master (fifo_to_axi4m_if.master)
//
// Optional feature macro: FIFO_TO_AXI4M_BRESP_ERR_EN adds the err output.
// ---------------------------------------------------------------------------
module fifo_to_axi4m
   import fifo_to_axi4m_pkg::*;
#(
   parameter int C_M_AXI_ID_WIDTH   = 4,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          kick,
   output logic                          busy,
   input  logic [31:0]                   write_num,
   input  logic [31:0]                   write_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] buf_din,
   input  logic                          buf_empty,
   output logic                          buf_re,
`ifdef FIFO_TO_AXI4M_BRESP_ERR_EN
   output logic                          err,
`endif
   fifo_to_axi4m_if.master               m_axi
);

   state_e                        state_q, state_d;
   logic [31:0]                   remaining_q, remaining_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addrBuf_q, addrBuf_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [7:0]                    awlen_q, awlen_d;
   logic [7:0]                    beatCnt_q, beatCnt_d;
`ifdef FIFO_TO_AXI4M_BRESP_ERR_EN
   logic                          err_q, err_d;
`endif

   logic [7:0]                    calcAwlen;
   logic [C_M_AXI_ADDR_WIDTH-1:0] calcNextAddr;
   logic [31:0]                   calcNextRemaining;
   logic                          wBeat;
   logic                          lastBeat;

   axi_burst_calc #(
      .ADDR_WIDTH (C_M_AXI_ADDR_WIDTH),
      .DATA_WIDTH (C_M_AXI_DATA_WIDTH)
   ) u_burstCalc (
      .remaining_i     (remaining_q),
      .addr_i          (addrBuf_q),
      .awlen_o         (calcAwlen),
      .nextAddr_o      (calcNextAddr),
      .nextRemaining_o (calcNextRemaining)
   );

   // Bus outputs are decoded from the state. W data comes straight from the
   // FIFO head so a beat can be sent every cycle; an empty FIFO simply holds
   // wvalid low instead of presenting stale data.
   always_comb begin
      busy          = (state_q != s_idle);
      m_axi.awid    = '0;
      m_axi.awaddr  = awaddr_q;
      m_axi.awlen   = awlen_q;
      m_axi.awsize  = axiSize(C_M_AXI_DATA_WIDTH);
      m_axi.awburst = BURST_INCR;
      m_axi.awlock  = 1'b0;
      m_axi.awcache = CACHE_DEFAULT;
      m_axi.awprot  = 3'b000;
      m_axi.awvalid = (state_q == s_addrissue);
      m_axi.wdata   = buf_din;
      m_axi.wstrb   = '1;
      m_axi.wvalid  = (state_q == s_data) && !buf_empty;
      m_axi.wlast   = (state_q == s_data) && (beatCnt_q == awlen_q);
      m_axi.bready  = (state_q == s_respwait);
      wBeat         = m_axi.wvalid && m_axi.wready;
      lastBeat      = wBeat && m_axi.wlast;
      buf_re        = wBeat;
   end

`ifdef FIFO_TO_AXI4M_BRESP_ERR_EN
   assign err = err_q;
`endif

   // Next-state logic. The zero-length check is made on the latched count in
   // s_addrcalc, so a kick with write_num==0 spends s_kick and s_addrcalc
   // busy and then returns to idle without issuing an address.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      addrBuf_d   = addrBuf_q;
      awaddr_d    = awaddr_q;
      awlen_d     = awlen_q;
      beatCnt_d   = beatCnt_q;
`ifdef FIFO_TO_AXI4M_BRESP_ERR_EN
      err_d       = err_q;
`endif
      case (state_q)
         s_idle: begin
            if (kick) begin
               state_d = s_kick;
            end
         end
         s_kick: begin
            remaining_d = write_num;
            addrBuf_d   = C_M_AXI_ADDR_WIDTH'(write_addr);
`ifdef FIFO_TO_AXI4M_BRESP_ERR_EN
            err_d       = 1'b0;
`endif
            state_d     = s_addrcalc;
         end
         s_addrcalc: begin
            if (remaining_q == 32'd0) begin
               state_d = s_idle;
            end else begin
               awlen_d     = calcAwlen;
               awaddr_d    = addrBuf_q;
               addrBuf_d   = calcNextAddr;
               remaining_d = calcNextRemaining;
               beatCnt_d   = 8'd0;
               state_d     = s_addrissue;
            end
         end
         s_addrissue: begin
            if (m_axi.awready) begin
               state_d = s_data;
            end
         end
         s_data: begin
            if (wBeat) begin
               beatCnt_d = beatCnt_q + 8'd1;
            end
            if (lastBeat) begin
               state_d = s_respwait;
            end
         end
         s_respwait: begin
            if (m_axi.bvalid) begin
`ifdef FIFO_TO_AXI4M_BRESP_ERR_EN
               if (m_axi.bresp != RESP_OKAY) begin
                  err_d = 1'b1;
               end
`endif
               state_d = (remaining_q != 32'd0) ? s_addrcalc : s_idle;
            end
         end
         default: begin
            state_d = s_idle;
         end
      endcase
   end

   // State and datapath registers; reset drops back to idle immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= s_idle;
         remaining_q <= '0;
         addrBuf_q   <= '0;
         awaddr_q    <= '0;
         awlen_q     <= '0;
         beatCnt_q   <= '0;
`ifdef FIFO_TO_AXI4M_BRESP_ERR_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         addrBuf_q   <= addrBuf_d;
         awaddr_q    <= awaddr_d;
         awlen_q     <= awlen_d;
         beatCnt_q   <= beatCnt_d;
`ifdef FIFO_TO_AXI4M_BRESP_ERR_EN
         err_q       <= err_d;
`endif
      end
   end

endmodule

// File: doc/fifo_to_axi4m.md
# fifo_to_axi4m

Write-side DMA engine that drains a first-word-fall-through FIFO into memory over an AXI4 master write port. On `kick` it splits `write_num` words starting at `write_addr` into INCR bursts of at most 64 beats and issues them one at a time: AW, then W beats, then B response. It is the write counterpart of the AXI4 read-to-FIFO engine and sits between the stream receive FIFO and the memory interconnect.

## Interface
- C_M_AXI_ID_WIDTH, 4, AWID/BID width
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width; power of two, ≥8
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- kick  in  1  start pulse; sampled only in s_idle
- busy  out  1  high whenever state ≠ s_idle
- write_num  in  32  word count, latched in s_kick
- write_addr  in  32  start byte address, latched in s_kick
- buf_din  in  DATA  FIFO head word (FWFT)
- buf_empty  in  1  FIFO empty
- buf_re  out  1  pop; = m_axi_wvalid & m_axi_wready
- m_axi_awid/awaddr/awlen[8]/awsize[3]/awburst[2]/awlock[1]/awcache[4]/awprot[3]/awvalid  out  AW channel
- m_axi_awready  in  1
- m_axi_wdata  out  DATA  = buf_din
- m_axi_wstrb  out  DATA/8  all ones
- m_axi_wlast/m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bid  in  ID; m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1
- err  out  1  only with FIFO_TO_AXI4M_BRESP_ERR_EN

## Operation
- Constants: awid 0, awburst 2'b01, awlock 0, awcache 4'b0010, awprot 0, awsize = clog2(DATA/8).
- States: s_idle → (kick) s_kick → s_addrcalc, or s_idle if write_num==0 → s_addrissue → (awready) s_data → (last beat accepted) s_respwait → (bvalid) s_addrcalc if remaining>0 else s_idle.
- s_addrcalc: len = min(remaining, 64); awlen ← len-1; awaddr ← addr_buf; addr_buf += (DATA/8)·len; remaining -= len; beat_cnt ← 0.
- awvalid = (state==s_addrissue); bready = (state==s_respwait).
- s_data: wvalid = !buf_empty; each wvalid&wready increments beat_cnt; wlast = (beat_cnt==awlen). FIFO underrun stalls wvalid low, never sends garbage.
- Callers keep bursts within 4 KB boundaries; block does not split them.
- kick while busy ignored. Address wraps modulo 2^32.

## Timing
- Reset: state s_idle; busy, awvalid, wvalid, wlast, bready, buf_re, err = 0; awaddr, awlen = 0.
- kick at cycle 0 → busy at 1, awvalid earliest at 3.
- W beats throughput 1/cycle when FIFO non-empty and wready high; wdata/wvalid/buf_re combinational from FIFO and wready.
- One outstanding burst; AW never overlaps W or B.
- Final bvalid handshake at cycle n → state s_idle, busy low at n+1.
- Reset mid-transfer: immediate return to s_idle, all valids low next cycle (system-reset use only).

## Configuration
- FIFO_TO_AXI4M_BRESP_ERR_EN defined: port `err` present; set sticky when bvalid&bready with bresp≠2'b00; cleared in s_kick; transfer continues.
- Undefined: no `err` port; bresp/bid ignored.

## Structure
- Package fifo_to_axi4m_pkg: state encoding, MAX_BURST_LENGTH=64, AXI constants (BURST_INCR, CACHE_DEFAULT, RESP_OKAY).
- Sub-module axi_burst_calc: combinational min(remaining,64), next addr, next remaining; shared with the read engine.

## Test plan
- write_num=16, addr 0x1000, FIFO full, ready always → one AW (awlen 15), 16 beats, wlast on 16th, busy low after B.
- write_num=130 → AW lens 63,63,1 at 0x0, 0x100, 0x200; 130 pops total.
- write_num=0 kick → no AW, busy high exactly 2 cycles.
- FIFO empty every other cycle, wready random → no beat while empty, data order preserved, wlast correct.
- With macro: bresp=2'b10 on burst 2 of 3 → err high from then until next kick; all 3 bursts complete.
- reset asserted mid-s_data → next cycle idle, wvalid/awvalid/bready 0; new kick runs cleanly.
